// File: rtl/user_str_loopback_engine_if.sv
// Stream, register and interrupt signals between the PCIe core and the loopback engine.
// The engine takes the slave modport, and the core (or a bench) takes the master modport.
interface user_str_loopback_engine_if #(
    parameter int DATA_W = 64
);
    logic              i_pcie_str_data_valid;
    logic              o_pcie_str_ack;
    logic [DATA_W-1:0] i_pcie_str_data;
    logic              o_pcie_str_data_valid;
    logic              i_pcie_str_ack;
    logic [DATA_W-1:0] o_pcie_str_data;
    logic [19:0]       i_user_addr;
    logic [31:0]       i_user_data;
    logic              i_user_wr_req;
    logic              i_user_rd_req;
    logic [31:0]       o_user_data;
    logic              o_user_rd_ack;
    logic              o_intr_req;
    logic              i_intr_ack;

    modport slave (
        input  i_pcie_str_data_valid, i_pcie_str_data, i_pcie_str_ack,
        input  i_user_addr, i_user_data, i_user_wr_req, i_user_rd_req, i_intr_ack,
        output o_pcie_str_ack, o_pcie_str_data_valid, o_pcie_str_data,
        output o_user_data, o_user_rd_ack, o_intr_req
    );

    modport master (
        output i_pcie_str_data_valid, i_pcie_str_data, i_pcie_str_ack,
        output i_user_addr, i_user_data, i_user_wr_req, i_user_rd_req, i_intr_ack,
        input  o_pcie_str_ack, o_pcie_str_data_valid, o_pcie_str_data,
        input  o_user_data, o_user_rd_ack, o_intr_req
    );
endinterface

// File: rtl/user_str_loopback_engine.sv
// Stream loopback endpoint: a first-word-fall-through FIFO with optional XOR scrambling,
// a small register window, and a popped-word threshold interrupt.
module user_str_loopback_engine #(
    parameter int          DATA_W     = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [19:0] BASE_ADDR  = 20'h00400
) (
    input  logic i_user_clk,
    input  logic i_rst,
    user_str_loopback_engine_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic          en_q, en_d, xor_q, xor_d;
    logic [31:0]   key_q, key_d, thresh_q, thresh_d;
    logic [31:0]   word_count_q, word_count_d, interval_cnt_q, interval_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    state_t        state_q, state_d;
    logic          rd_ack_q, rd_ack_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic              in_win, wr_hit, rd_hit, clr, push, pop, full, empty;
    logic [2:0]        slot;
    logic [DATA_W-1:0] mask;
    logic [31:0]       status;

    assign in_win = (bus.i_user_addr[19:5] == BASE_ADDR[19:5]);
    assign slot   = bus.i_user_addr[4:2];
    assign wr_hit = bus.i_user_wr_req && in_win;
    assign rd_hit = bus.i_user_rd_req && in_win;
    assign clr    = wr_hit && (slot == 3'd0) && bus.i_user_data[2];

    assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign mask  = xor_q ? {(DATA_W/32){key_q}} : '0;

    // A CLR write voids any handshake that lands in the same cycle.
    assign push = bus.i_pcie_str_data_valid && bus.o_pcie_str_ack && !clr;
    assign pop  = bus.o_pcie_str_data_valid && bus.i_pcie_str_ack && !clr;

    assign bus.o_pcie_str_ack        = en_q && !full;
    assign bus.o_pcie_str_data_valid = en_q && !empty;
    assign bus.o_pcie_str_data       = fifo_mem[rd_ptr_q];
    assign bus.o_user_rd_ack         = rd_ack_q;
    assign bus.o_user_data           = rd_data_q;
    assign bus.o_intr_req            = (state_q == S_REQ);

    assign status = {{(16-AW-1){1'b0}}, level_q, 14'd0, full, empty};

    always_comb begin
        en_d           = en_q;
        xor_d          = xor_q;
        key_d          = key_q;
        thresh_d       = thresh_q;
        word_count_d   = word_count_q;
        interval_cnt_d = interval_cnt_q + 32'(pop);
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        state_d        = state_q;
        rd_ack_d       = rd_hit;
        rd_data_d      = 32'd0;

        if (wr_hit) begin
            case (slot)
                3'd0: begin
                    en_d  = bus.i_user_data[0];
                    xor_d = bus.i_user_data[1];
                end
                3'd1:    key_d    = bus.i_user_data;
                3'd2:    thresh_d = bus.i_user_data;
                default: ;
            endcase
        end

        if (rd_hit) begin
            case (slot)
                3'd0:    rd_data_d = {30'd0, xor_q, en_q};
                3'd1:    rd_data_d = key_q;
                3'd2:    rd_data_d = thresh_q;
                3'd3:    rd_data_d = word_count_q;
                3'd4:    rd_data_d = status;
                default: rd_data_d = 32'd0;
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            word_count_d = word_count_q + 32'd1;
        end
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);

        // The threshold is compared against the registered count; the pop of this
        // cycle is carried into the remainder.
        case (state_q)
            S_IDLE: if (thresh_q != 32'd0 && interval_cnt_q >= thresh_q) begin
                state_d        = S_REQ;
                interval_cnt_d = interval_cnt_q + 32'(pop) - thresh_q;
            end
            S_REQ:   if (bus.i_intr_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            level_d        = '0;
            word_count_d   = 32'd0;
            interval_cnt_d = 32'd0;
            state_d        = S_IDLE;
        end
    end

    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            en_q           <= 1'b0;
            xor_q          <= 1'b0;
            key_q          <= 32'd0;
            thresh_q       <= 32'd0;
            word_count_q   <= 32'd0;
            interval_cnt_q <= 32'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            state_q        <= S_IDLE;
            rd_ack_q       <= 1'b0;
            rd_data_q      <= 32'd0;
        end else begin
            en_q           <= en_d;
            xor_q          <= xor_d;
            key_q          <= key_d;
            thresh_q       <= thresh_d;
            word_count_q   <= word_count_d;
            interval_cnt_q <= interval_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            state_q        <= state_d;
            rd_ack_q       <= rd_ack_d;
            rd_data_q      <= rd_data_d;
        end
    end

    always_ff @(posedge i_user_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.i_pcie_str_data ^ mask;
    end
endmodule
